// File: rtl/mp64_memarb.sv
// ---------------------------------------------------------------------------
// mp64_memarb
// Four-port round-robin arbiter that funnels single-beat read/write requests
// into one downstream port on the external-memory controller's CPU side.
// A granted transaction either finishes when m_ack arrives or is ended by a
// timeout after TIMEOUT_CYC cycles, in which case err is raised with the ack.
//
// Parameters
//   TIMEOUT_CYC   cycles WAIT may last before a timeout completion (2..65535)
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[3:0]      per-port request, held until that port's ack
//   addr[127:0]   per-port byte address, port i at [i*32 +: 32]
//   wdata[255:0]  per-port write data, port i at [i*64 +: 64]
//   wen[3:0]      per-port write enable (1 = write)
//   lock[3:0]     per-port bus lock (only with MP64_MEMARB_LOCK_EN)
//   rdata[63:0]   read data shared by all ports, valid while ack is high
//   ack[3:0]      per-port one-cycle completion pulse
//   err           timeout flag, valid with ack
//   m_req/m_addr/m_wdata/m_wen   downstream request, held stable in WAIT
//   m_rdata/m_ack                downstream response
//
// Build option
//   MP64_MEMARB_LOCK_EN  adds the lock input. A port whose lock bit is high
//   while its ack is out keeps the bus: the next grants go only to it until
//   it completes a transaction with lock low, or drops lock while idle.
// ---------------------------------------------------------------------------
module mp64_memarb #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] addr,
    input  logic [255:0] wdata,
    input  logic [3:0]   wen,
`ifdef MP64_MEMARB_LOCK_EN
    input  logic [3:0]   lock,
`endif
    output logic [63:0]  rdata,
    output logic [3:0]   ack,
    output logic         err,
    output logic         m_req,
    output logic [31:0]  m_addr,
    output logic [63:0]  m_wdata,
    output logic         m_wen,
    input  logic [63:0]  m_rdata,
    input  logic         m_ack
);

    // state | meaning
    // IDLE  | pick the next requester, latch its command onto m_*
    // WAIT  | m_req held; wait for m_ack or the timeout counter to expire
    // DONE  | ack/err pulse is out; no grant this cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Down-counter is loaded with TIMEOUT_CYC-1 at grant so that terminal
    // count zero is seen in the TIMEOUT_CYC-th WAIT cycle.
    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT_CYC - 1);

    state_t       state;
    logic [1:0]   grant;
    logic [1:0]   last_grant;
    logic [15:0]  cnt;

    logic [3:0][31:0] addr_v;
    logic [3:0][63:0] wdata_v;

    logic         rr_valid;
    logic [1:0]   rr_grant;
    logic [1:0]   rr_idx;
    logic         sel_valid;
    logic [1:0]   sel_grant;

    assign addr_v  = addr;
    assign wdata_v = wdata;

    // Round-robin search starting at last_grant+1; walking the offsets from
    // 4 down to 1 leaves the nearest requester as the final winner.
    always_comb begin
        rr_valid = 1'b0;
        rr_grant = last_grant;
        rr_idx   = last_grant;
        for (int i = 4; i >= 1; i--) begin
            rr_idx = last_grant + 2'(i);
            if (req[rr_idx]) begin
                rr_valid = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

`ifdef MP64_MEMARB_LOCK_EN
    logic lock_hold;
    logic lock_release;

    // While held, only the locking port may be granted. The hold falls away
    // when that port is not requesting and has dropped its lock bit.
    always_comb begin
        sel_valid    = rr_valid;
        sel_grant    = rr_grant;
        lock_release = 1'b0;
        if (lock_hold) begin
            if (req[last_grant]) begin
                sel_valid = 1'b1;
                sel_grant = last_grant;
            end else if (lock[last_grant]) begin
                sel_valid = 1'b0;
            end else begin
                lock_release = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_valid = rr_valid;
        sel_grant = rr_grant;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            cnt        <= 16'd0;
            m_req      <= 1'b0;
            m_addr     <= 32'd0;
            m_wdata    <= 64'd0;
            m_wen      <= 1'b0;
            ack        <= 4'd0;
            err        <= 1'b0;
            rdata      <= 64'd0;
`ifdef MP64_MEMARB_LOCK_EN
            lock_hold  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant   <= sel_grant;
                        m_addr  <= addr_v[sel_grant];
                        m_wdata <= wdata_v[sel_grant];
                        m_wen   <= wen[sel_grant];
                        m_req   <= 1'b1;
                        cnt     <= CNT_LOAD;
                        state   <= WAIT;
                    end
`ifdef MP64_MEMARB_LOCK_EN
                    if (lock_release) begin
                        lock_hold <= 1'b0;
                    end
`endif
                end
                WAIT: begin
                    // A real response wins over a timeout in the same cycle.
                    if (m_ack) begin
                        ack        <= 4'b0001 << grant;
                        rdata      <= m_wen ? 64'd0 : m_rdata;
                        err        <= 1'b0;
                        m_req      <= 1'b0;
                        last_grant <= grant;
                        cnt        <= 16'd0;
                        state      <= DONE;
                    end else if (cnt == 16'd0) begin
                        ack        <= 4'b0001 << grant;
                        rdata      <= 64'd0;
                        err        <= 1'b1;
                        m_req      <= 1'b0;
                        last_grant <= grant;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE: begin
                    ack   <= 4'd0;
                    err   <= 1'b0;
                    state <= IDLE;
`ifdef MP64_MEMARB_LOCK_EN
                    // last_grant already names the port whose ack is out.
                    lock_hold <= lock[last_grant];
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_memarb.sv
// ---------------------------------------------------------------------------
// tb_mp64_memarb
// Scoreboard bench for mp64_memarb. Each stimulus step pushes the expected
// completion (port, data, err, latency, downstream command) into a queue;
// a monitor compares grants and acks against the queue front as they appear.
// A simple memory model answers m_req after resp_delay cycles (0 = never).
// ---------------------------------------------------------------------------
module tb_mp64_memarb;

    localparam int TO = 8;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        wen;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][31:0] addr_v;
    logic [3:0][63:0] wdata_v;
    logic [3:0]       wen;
    logic [63:0]      rdata;
    logic [3:0]       ack;
    logic             err;
    logic             m_req;
    logic [31:0]      m_addr;
    logic [63:0]      m_wdata;
    logic             m_wen;
    logic [63:0]      m_rdata;
    logic             m_ack;
    logic             ack_resp;
    logic             ack_stray;
`ifdef MP64_MEMARB_LOCK_EN
    logic [3:0]       lock;
`endif

    int          issued [4];
    int          done_cnt [4];
    exp_t        q [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          resp_delay = 2;
    bit          use_fixed = 1'b0;
    logic [63:0] rd_fixed = 64'd0;

    always #5 clk = ~clk;

    assign m_ack = ack_resp | ack_stray;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            req[p] = (issued[p] != done_cnt[p]);
        end
    end

    mp64_memarb #(.TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr_v),
        .wdata   (wdata_v),
        .wen     (wen),
`ifdef MP64_MEMARB_LOCK_EN
        .lock    (lock),
`endif
        .rdata   (rdata),
        .ack     (ack),
        .err     (err),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wen   (m_wen),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic expect_txn(input int p, input bit timeout);
        exp_t e;
        e.port  = p;
        e.addr  = addr_v[p];
        e.wdata = wdata_v[p];
        e.wen   = wen[p];
        e.err   = timeout;
        e.lat   = timeout ? TO : resp_delay;
        if (timeout || wen[p])
            e.rdata = 64'd0;
        else if (use_fixed)
            e.rdata = rd_fixed;
        else
            e.rdata = {addr_v[p], ~addr_v[p]};
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || req != 4'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 64'(q.size()), 64'd0);
        chk("drain_req", 64'(req), 64'd0);
    endtask

    task automatic wait_mreq(input int budget);
        int n = 0;
        while (!m_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("mreq_seen", 64'(m_req), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},     64'(ack),   64'd0);
        chk({tag, "_err"},     64'(err),   64'd0);
        chk({tag, "_rdata"},   rdata,      64'd0);
        chk({tag, "_m_req"},   64'(m_req), 64'd0);
        chk({tag, "_m_addr"},  64'(m_addr), 64'd0);
        chk({tag, "_m_wdata"}, m_wdata,    64'd0);
        chk({tag, "_m_wen"},   64'(m_wen), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: ack resp_delay cycles after m_req is first seen.
    initial begin
        int wcnt = 0;
        ack_resp = 1'b0;
        m_rdata  = 64'd0;
        forever begin
            @(negedge clk);
            if (ack_resp) begin
                ack_resp = 1'b0;
                wcnt     = 0;
            end else if (m_req && resp_delay != 0) begin
                wcnt++;
                if (wcnt == resp_delay) begin
                    ack_resp = 1'b1;
                    m_rdata  = use_fixed ? rd_fixed : {m_addr, ~m_addr};
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: grant and completion checks against the scoreboard front.
    initial begin
        bit   prev_mreq = 1'b0;
        int   t_mreq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_mreq = 1'b0;
                continue;
            end
            if (m_req && !prev_mreq) begin
                t_mreq = cyc;
                chk("grant_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("grant_m_addr",  64'(m_addr), 64'(q[0].addr));
                    chk("grant_m_wdata", m_wdata,     q[0].wdata);
                    chk("grant_m_wen",   64'(m_wen),  64'(q[0].wen));
                end
            end
            if (ack != 4'd0) begin
                chk("ack_onehot",   64'($countones(ack)), 64'd1);
                chk("mreq_in_done", 64'(m_req), 64'd0);
                chk("ack_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ack_port",    64'(ack), 64'(4'b0001 << e.port));
                    chk("ack_rdata",   rdata, e.rdata);
                    chk("ack_err",     64'(err), 64'(e.err));
                    chk("ack_latency", 64'(cyc - t_mreq), 64'(e.lat));
                end
                for (int p = 0; p < 4; p++) begin
                    if (ack[p]) done_cnt[p]++;
                end
            end
            prev_mreq = m_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int base3;
        int n;
        rst_n     = 1'b0;
        ack_stray = 1'b0;
        addr_v    = '0;
        wdata_v   = '0;
        wen       = 4'd0;
`ifdef MP64_MEMARB_LOCK_EN
        lock      = 4'd0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on port 0 with fixed response data.
        use_fixed = 1'b1;
        rd_fixed  = 64'hDEAD_BEEF_1234_5678;
        addr_v[0]  = 32'h8000_0100;
        wdata_v[0] = 64'h0000_0000_0000_1111;
        wen[0]     = 1'b0;
        expect_txn(0, 1'b0);
        issued[0]++;
        drain(50);

        // Write on port 2: read data must come back as zero.
        use_fixed  = 1'b0;
        addr_v[2]  = 32'h1000_0200;
        wdata_v[2] = 64'hCAFE_BABE_0000_0001;
        wen[2]     = 1'b1;
        expect_txn(2, 1'b0);
        issued[2]++;
        drain(50);

        // All four ports requesting from reset: strict 0,1,2,3 rotation.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            addr_v[p]  = 32'h2000_0000 + 32'(p * 16);
            wdata_v[p] = {32'(p), 32'hA5A5_0000};
        end
        wen = 4'b1010;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) expect_txn(p, 1'b0);
        end
        for (int p = 0; p < 4; p++) issued[p] += 2;
        drain(200);

        // Timeout on port 1, then a stray m_ack while idle.
        resp_delay = 0;
        addr_v[1]  = 32'h3000_0010;
        wen[1]     = 1'b0;
        expect_txn(1, 1'b1);
        issued[1]++;
        drain(50);
        @(negedge clk);
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_m_req", 64'(m_req), 64'd0);
        chk("stray_ack",   64'(ack),   64'd0);

        // Reset in the middle of WAIT: outputs clear without waiting for a clock.
        addr_v[2] = 32'h4000_0020;
        wen[2]    = 1'b0;
        expect_txn(2, 1'b0);
        issued[2]++;
        wait_mreq(10);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        q.delete();
        issued[2] = done_cnt[2];
        @(negedge clk);
        rst_n      = 1'b1;
        resp_delay = 2;
        addr_v[0]  = 32'h5000_0000;
        addr_v[3]  = 32'h5000_0030;
        wen[0]     = 1'b0;
        wen[3]     = 1'b0;
        expect_txn(0, 1'b0);
        expect_txn(3, 1'b0);
        issued[0]++;
        issued[3]++;
        drain(100);

`ifdef MP64_MEMARB_LOCK_EN
        // Port 3 locks for two transactions: 0,1,2,3,3,3 then back to 0.
        wen  = 4'b0000;
        lock = 4'b1000;
        for (int p = 0; p < 4; p++) addr_v[p] = 32'h6000_0000 + 32'(p * 8);
        expect_txn(0, 1'b0);
        expect_txn(1, 1'b0);
        expect_txn(2, 1'b0);
        expect_txn(3, 1'b0);
        expect_txn(3, 1'b0);
        expect_txn(3, 1'b0);
        expect_txn(0, 1'b0);
        base3 = done_cnt[3];
        issued[0] += 2;
        issued[1] += 1;
        issued[2] += 1;
        issued[3] += 3;
        n = 0;
        while (done_cnt[3] < base3 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("lock_second_ack", 64'(done_cnt[3] - base3 >= 2), 64'd1);
        @(negedge clk);
        lock = 4'b0000;
        drain(200);
`else
        base3 = 0;
        n     = base3;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mp64_memarb.md
MP64_MEMARB -- requirements
Module: mp64_memarb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, giving the max cycles WAIT holds before a timeout completion (range 2..65535).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  in  4  per-port request; held high until that port's ack.
REQ-005 SHALL have port addr  in  128  per-port byte address, port i at [i*32 +: 32].
REQ-006 SHALL have port wdata  in  256  per-port write data, port i at [i*64 +: 64].
REQ-007 SHALL have port wen  in  4  per-port write enable (1 = write).
REQ-008 SHALL have port rdata  out  64  read data shared by all ports; valid in the ack cycle.
REQ-009 SHALL have port ack  out  4  per-port one-cycle completion pulse.
REQ-010 SHALL have port err  out  1  timeout flag, valid with ack.
REQ-011 SHALL have ports m_req out 1, m_addr out 32, m_wdata out 64, m_wen out 1, m_rdata in 64, m_ack in 1, forming the downstream single-beat port into the external-memory controller's CPU side.

Function
REQ-012 SHALL implement FSM IDLE, WAIT, DONE; all outputs registered.
REQ-013 IDLE: on any req bit high, SHALL select grant g by round-robin starting at last_grant+1 mod 4, latch addr/wdata/wen of g onto m_*, set m_req=1 and go to WAIT; m_req is therefore high 1 cycle after req is sampled.
REQ-014 WAIT: m_req and m_* SHALL stay constant; req changes on any port SHALL be ignored.
REQ-015 WAIT on m_ack=1: SHALL set ack[g]=1, rdata=m_rdata (0 for writes), err=0, m_req=0, last_grant=g, go to DONE.
REQ-016 WAIT cycle counter reaching TIMEOUT_CYC without m_ack: SHALL set ack[g]=1, err=1, rdata=0, m_req=0, last_grant=g, go to DONE.
REQ-017 DONE: SHALL clear ack and err and return to IDLE without granting; a granted port thus sees at least one idle cycle to drop req.
REQ-018 m_ack seen outside WAIT SHALL be ignored.
REQ-019 At most one ack bit SHALL be high in any cycle; m_req SHALL never be high in DONE.
REQ-020 With all four ports requesting continuously, grants SHALL rotate strictly 0,1,2,3,0... (no port waits more than 3 transactions).

Reset
REQ-021 rst_n low SHALL immediately force IDLE, m_req=0, m_addr=0, m_wdata=0, m_wen=0, ack=0, err=0, rdata=0, counter=0, last_grant=3 (port 0 first).
REQ-022 Reset asserted in WAIT SHALL abandon the transaction with no ack; first grant after release follows REQ-021.

Configuration
REQ-023 With MP64_MEMARB_LOCK_EN defined, SHALL add input lock (4 bits); if lock[g] is high in the ack cycle, the next IDLE SHALL grant only g (others held off) until g completes a transaction with lock[g] low, or lock[g] drops while g is not requesting, which releases to round-robin.
REQ-024 Without MP64_MEMARB_LOCK_EN, no lock port SHALL exist and arbitration is pure round-robin.

Verification
REQ-025 Reset then req=4'b0001, addr0=0x8000_0100, wen=0; m_ack with m_rdata=0xDEAD_BEEF_1234_5678 -> m_addr=0x8000_0100, ack=4'b0001 one cycle, rdata matches, err=0.
REQ-026 req=4'b1111 held, m_ack 2 cycles after each m_req -> ack order 0,1,2,3,0; m_req low in every DONE cycle.
REQ-027 Write port 2, wdata2=0xCAFE_BABE_0000_0001 -> m_wen=1, m_wdata matches, ack=4'b0100.
REQ-028 TIMEOUT_CYC=8, port 1 request, no m_ack -> ack[1] and err=1 exactly 8 cycles after m_req rises; m_ack pulsed in next IDLE ignored.
REQ-029 Reset pulsed mid-WAIT -> all outputs 0 asynchronously; next req=4'b1001 grants port 0 first.
REQ-030 (LOCK_EN) port 3 lock=1 for two transactions while req=4'b1111 -> grants 3,3,3 then 0.
